// File: rtl/alu_op_issuer.sv
// alu_op_issuer
//   Issues one operation at a time to an external fixed-latency ALU and holds
//   the captured result until the consumer takes it.
//
//   Request side : REQ_VALID/REQ_READY handshake carrying REQ_MODE, REQ_CMD,
//                  REQ_OPA, REQ_OPB, REQ_CIN and REQ_INP_VALID.
//   ALU drive    : CE plus registered MODE, CMD, OPA, OPB, CIN, INP_VALID.
//   ALU return   : RES and flags ERR, OFLOW, COUT, G, L, E.
//   Response     : RSP_VALID/RSP_READY handshake carrying RSP_RES and
//                  RSP_FLAGS = {ERR,OFLOW,COUT,G,L,E}.
//   Status       : BUSY (not idle), TXN_CNT (completed responses, wraps).
//
//   The result is sampled exactly ALU_LAT rising edges after the accept edge.
//   ALU_LAT must be in the range 1..15.
module alu_op_issuer #(
  parameter int DATA_WIDTH = 8,
  parameter int CMD_WIDTH  = 4,
  parameter int ALU_LAT    = 2
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    REQ_VALID,
  output logic                    REQ_READY,
  input  logic                    REQ_MODE,
  input  logic [CMD_WIDTH-1:0]    REQ_CMD,
  input  logic [DATA_WIDTH-1:0]   REQ_OPA,
  input  logic [DATA_WIDTH-1:0]   REQ_OPB,
  input  logic                    REQ_CIN,
  input  logic [1:0]              REQ_INP_VALID,
  output logic                    CE,
  output logic                    MODE,
  output logic [CMD_WIDTH-1:0]    CMD,
  output logic [DATA_WIDTH-1:0]   OPA,
  output logic [DATA_WIDTH-1:0]   OPB,
  output logic                    CIN,
  output logic [1:0]              INP_VALID,
  input  logic [2*DATA_WIDTH-1:0] RES,
  input  logic                    ERR,
  input  logic                    OFLOW,
  input  logic                    COUT,
  input  logic                    G,
  input  logic                    L,
  input  logic                    E,
  output logic                    RSP_VALID,
  input  logic                    RSP_READY,
  output logic [2*DATA_WIDTH-1:0] RSP_RES,
  output logic [5:0]              RSP_FLAGS,
  output logic                    BUSY,
  output logic [7:0]              TXN_CNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT);

  state_t     state;
  logic [3:0] lat_cnt;

  // Gated by RST so the request side reads as not-ready while reset is held,
  // even though state is already forced to IDLE asynchronously.
  assign REQ_READY = (state == IDLE) && !RST;
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      lat_cnt   <= '0;
      CE        <= 1'b0;
      MODE      <= 1'b0;
      CMD       <= '0;
      OPA       <= '0;
      OPB       <= '0;
      CIN       <= 1'b0;
      INP_VALID <= '0;
      RSP_VALID <= 1'b0;
      RSP_RES   <= '0;
      RSP_FLAGS <= '0;
      TXN_CNT   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            MODE      <= REQ_MODE;
            CMD       <= REQ_CMD;
            OPA       <= REQ_OPA;
            OPB       <= REQ_OPB;
            CIN       <= REQ_CIN;
            INP_VALID <= REQ_INP_VALID;
            CE        <= 1'b1;
            lat_cnt   <= LAT_LOAD;
            state     <= DRIVE;
          end
        end
        DRIVE: begin
          // Counter holds ALU_LAT on the first edge after accept, so reaching
          // 1 lines the capture up with the ALU_LAT-th edge.
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            RSP_RES   <= RES;
            RSP_FLAGS <= {ERR, OFLOW, COUT, G, L, E};
            RSP_VALID <= 1'b1;
            CE        <= 1'b0;
            INP_VALID <= '0;
            state     <= RESP;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            TXN_CNT   <= TXN_CNT + 8'd1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_op_issuer.md
ALU_OP_ISSUER -- requirements
Module: alu_op_issuer

Interface
REQ-001 Parameters SHALL be DATA_WIDTH, default 8, for the operand width.
REQ-002 Parameters SHALL include CMD_WIDTH, default 4, for the command width.
REQ-003 Parameters SHALL include ALU_LAT, default 2, for the ALU result latency in clock edges; legal values are 1 to 15.
REQ-004 Ports, in order, SHALL be as follows; the clock and reset come first.
- CLK  in  1  single clock; all logic on rising edge.
- RST  in  1  asynchronous, active-high reset.
- REQ_VALID  in  1  request offered.
- REQ_READY  out  1  request accepted this cycle when high with REQ_VALID.
- REQ_MODE  in  1  ALU mode.
- REQ_CMD  in  CMD_WIDTH  ALU command.
- REQ_OPA, REQ_OPB  in  DATA_WIDTH  operands.
- REQ_CIN  in  1  carry-in.
- REQ_INP_VALID  in  2  operand-valid code.
- CE  out  1  ALU clock enable.
- MODE, CMD, OPA, OPB, CIN, INP_VALID  out  as REQ_*  registered ALU drive.
- RES  in  2*DATA_WIDTH  ALU result.
- ERR, OFLOW, COUT, G, L, E  in  1 each  ALU flags.
- RSP_VALID  out  1  response available.
- RSP_READY  in  1  response consumed when high with RSP_VALID.
- RSP_RES  out  2*DATA_WIDTH  captured RES.
- RSP_FLAGS  out  6  captured {ERR,OFLOW,COUT,G,L,E}, ERR at MSB.
- BUSY  out  1  high when the state is not IDLE.
- TXN_CNT  out  8  completed-response count.

Function
REQ-005 The FSM SHALL have three states (IDLE, DRIVE, RESP) held in registered state, with no other reachable state.
REQ-006 REQ_READY SHALL be 1 only in IDLE with RST low; it is combinational from state only and independent of REQ_VALID.
REQ-007 On an accept edge (IDLE, REQ_VALID=1) the block SHALL register all REQ_* fields onto the ALU drive outputs, set CE=1, load the latency counter with ALU_LAT, and enter DRIVE.
REQ-008 In DRIVE the ALU drive outputs SHALL hold constant, and REQ_* changes SHALL be ignored.
REQ-009 In DRIVE the counter SHALL decrement each edge; on the edge where the counter equals 1 it SHALL capture RES into RSP_RES and the flags into RSP_FLAGS, set RSP_VALID=1, set CE=0 and INP_VALID=0, and enter RESP.
- Capture therefore occurs exactly ALU_LAT edges after the accept edge.
REQ-010 In RESP, RSP_VALID, RSP_RES and RSP_FLAGS SHALL hold unchanged until an edge with RSP_READY=1.
- On that edge RSP_VALID SHALL go to 0, TXN_CNT SHALL increment, and the FSM SHALL return to IDLE.
REQ-011 TXN_CNT SHALL wrap from 255 to 0 without any flag.
REQ-012 Back-to-back operation: a new request SHALL be acceptable on the edge after the response handshake; peak throughput is one operation per ALU_LAT+2 cycles.
REQ-013 ERR=1 captured from the ALU SHALL be passed through in RSP_FLAGS[5] and SHALL NOT alter FSM flow.
REQ-014 RSP_VALID SHALL never be asserted in IDLE or DRIVE.
REQ-015 CE SHALL be 1 only in DRIVE.

Reset
REQ-016 RST=1 SHALL immediately, without waiting for a clock edge, force the following, overriding any transaction in progress:
- state IDLE;
- CE, INP_VALID, MODE, CMD, OPA, OPB, CIN = 0;
- RSP_VALID=0, RSP_RES=0, RSP_FLAGS=0;
- TXN_CNT=0, BUSY=0, REQ_READY=0.
REQ-017 A transaction interrupted by reset SHALL produce no response.
REQ-018 After RST falls, the first rising edge SHALL be able to accept a request.

Verification
REQ-019 The bench SHALL cover the following directed scenarios, each using a behavioural ALU model with the latency ALU_LAT=2.
- Reset check: assert RST mid-cycle -> all outputs 0 before the next edge; after release, REQ_READY=1.
- Single add: MODE=1, CMD=0000, OPA=217, OPB=117, CIN=1, REQ_INP_VALID=11.
  - One edge after accept: OPA=217, OPB=117, CE=1.
  - Two edges after accept: RSP_VALID=1 and RSP_RES=335 (model); TXN_CNT=1 after the handshake.
- Backpressure: hold RSP_READY=0 for 5 cycles after RSP_VALID -> RSP_RES and RSP_FLAGS stable, REQ_READY=0, TXN_CNT unchanged; RSP_READY=1 -> IDLE on the next edge.
- Operand change while busy: alter REQ_OPA to 0 during DRIVE -> OPA stays 217 and the response is unchanged.
- Reset mid-DRIVE: assert RST one edge after accept -> no RSP_VALID ever for that request; TXN_CNT=0.
- Wrap and flags: 256 requests with MODE=0, CMD=0000, OPA=15, OPB=3 -> TXN_CNT returns to 0; an ERR=1 injection appears as RSP_FLAGS=6'b1xxxxx.
